// File: rtl/cr16_run_controller.sv
// cr16_run_controller
// ---------------------------------------------------------------------------
// Run-control sequencer for the CR16 core. After reset it holds the core
// disabled for P_COLD_CYCLES cycles while block RAM warms up. It then waits
// in PAUSE and from there can:
//   - free-run the core while I_RUN is high,
//   - single-step it on each rising edge of I_STEP,
//   - pause it at a PC breakpoint (optional feature, see below).
// Once the PC goes above P_MAX_PC it halts the core for good in DONE.
// It also counts the cycles in which the core was enabled.
//
// Optional feature macro: CR16_RUN_CTRL_BREAKPOINT_EN
//   defined   : breakpoint compare on I_BREAK_EN / I_BREAK_PC, with a skip
//               flag so execution can resume from the breakpoint PC.
//   undefined : no breakpoint; I_BREAK_EN / I_BREAK_PC are ignored.
//
// Ports:
//   I_CLK          clock; all state changes on the rising edge
//   I_NRESET       synchronous active-low reset
//   I_RUN          level, 1 = free-run requested
//   I_STEP         single-step request, rising edge acts
//   I_BREAK_EN     breakpoint compare enable
//   I_BREAK_PC     breakpoint address
//   I_PC           current PC from the core
//   O_CR16_ENABLE  core enable (combinational on I_PC, so no overshoot)
//   O_STATE        state code: COLD=0 PAUSE=1 RUN=2 STEP=3 DONE=4
//   O_DONE         1 in DONE
//   O_CYCLE_COUNT  saturating count of cycles with O_CR16_ENABLE=1
// ---------------------------------------------------------------------------
module cr16_run_controller #(
  parameter logic [15:0] P_COLD_CYCLES       = 16'd2,
  parameter logic [15:0] P_MAX_PC            = 16'd32,
  parameter int          P_CYCLE_COUNT_WIDTH = 32
) (
  input  logic                           I_CLK,
  input  logic                           I_NRESET,
  input  logic                           I_RUN,
  input  logic                           I_STEP,
  input  logic                           I_BREAK_EN,
  input  logic [15:0]                    I_BREAK_PC,
  input  logic [15:0]                    I_PC,
  output logic                           O_CR16_ENABLE,
  output logic [2:0]                     O_STATE,
  output logic                           O_DONE,
  output logic [P_CYCLE_COUNT_WIDTH-1:0] O_CYCLE_COUNT
);

  typedef enum logic [2:0] {
    ST_COLD  = 3'd0,
    ST_PAUSE = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [P_CYCLE_COUNT_WIDTH-1:0] CNT_MAX_C = {P_CYCLE_COUNT_WIDTH{1'b1}};
  localparam logic [P_CYCLE_COUNT_WIDTH-1:0] CNT_ONE_C =
    {{(P_CYCLE_COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                           state_r;
  logic [15:0]                      cold_cnt_r;
  logic                             step_q_r;
  logic                             done_r;
  logic [P_CYCLE_COUNT_WIDTH-1:0]   cycle_cnt_r;

  logic over_s;
  logic step_edge_s;
  logic bp_hit_s;
  logic active_s;
  logic enable_s;

  assign over_s      = (I_PC > P_MAX_PC);
  assign step_edge_s = I_STEP & ~step_q_r;
  assign active_s    = (state_r == ST_RUN) | (state_r == ST_STEP);

`ifdef CR16_RUN_CTRL_BREAKPOINT_EN
  logic skip_r;
  logic leave_pause_s;
  logic pause_entry_s;

  // skip masks the breakpoint for the first enabled cycle after leaving
  // PAUSE, so a run or step started at the breakpoint PC makes progress.
  assign bp_hit_s = I_BREAK_EN & (I_PC == I_BREAK_PC) & ~skip_r;

  assign leave_pause_s = (state_r == ST_PAUSE) & ~over_s & (I_RUN | step_edge_s);
  assign pause_entry_s =
      ((state_r == ST_COLD) & (cold_cnt_r == (P_COLD_CYCLES - 16'd1)))
    | ((state_r == ST_RUN)  & ~over_s & (bp_hit_s | ~I_RUN))
    | ((state_r == ST_STEP) & ~over_s);

  // Skip flag: set when leaving PAUSE, cleared after the first enabled
  // cycle or on return to PAUSE.
  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      skip_r <= 1'b0;
    end else if (leave_pause_s) begin
      skip_r <= 1'b1;
    end else if (enable_s | pause_entry_s) begin
      skip_r <= 1'b0;
    end else begin
      skip_r <= skip_r;
    end
  end
`else
  logic unused_break_s;

  assign bp_hit_s       = 1'b0;
  assign unused_break_s = ^{I_BREAK_EN, I_BREAK_PC};
`endif

  // Enable reacts to I_PC in the same cycle so the core never executes
  // past P_MAX_PC or a breakpoint.
  assign enable_s = active_s & ~over_s & ~bp_hit_s;

  // Run-control FSM, step-edge detector and enabled-cycle counter.
  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      state_r     <= ST_COLD;
      cold_cnt_r  <= 16'd0;
      step_q_r    <= 1'b0;
      done_r      <= 1'b0;
      cycle_cnt_r <= {P_CYCLE_COUNT_WIDTH{1'b0}};
    end else begin
      step_q_r <= I_STEP;

      if (enable_s && (cycle_cnt_r != CNT_MAX_C)) begin
        cycle_cnt_r <= cycle_cnt_r + CNT_ONE_C;
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end

      case (state_r)
        ST_COLD: begin
          cold_cnt_r <= cold_cnt_r + 16'd1;
          if (cold_cnt_r == (P_COLD_CYCLES - 16'd1)) begin
            state_r <= ST_PAUSE;
          end else begin
            state_r <= ST_COLD;
          end
        end
        ST_PAUSE: begin
          // RUN wins over a simultaneous step edge.
          if (over_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else if (I_RUN) begin
            state_r <= ST_RUN;
          end else if (step_edge_s) begin
            state_r <= ST_STEP;
          end else begin
            state_r <= ST_PAUSE;
          end
        end
        ST_RUN: begin
          if (over_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else if (bp_hit_s || !I_RUN) begin
            state_r <= ST_PAUSE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_STEP: begin
          // Exactly one enabled cycle; step edges seen here are dropped.
          if (over_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_PAUSE;
          end
        end
        ST_DONE: begin
          state_r <= ST_DONE;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= ST_COLD;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign O_CR16_ENABLE = enable_s;
  assign O_STATE       = state_r;
  assign O_DONE        = done_r;
  assign O_CYCLE_COUNT = cycle_cnt_r;

endmodule

// File: doc/cr16_run_controller.md
# cr16_run_controller

Run-control sequencer for the CR16 core on the FPGA top level. It holds the core disabled while BRAM warms up, then runs it freely, single-steps it from a pushbutton, or pauses it at a PC breakpoint. It terminally halts the core once the PC passes a configured maximum, and counts the cycles in which the core was enabled. It drives the core's `I_ENABLE` and replaces ad-hoc clock gating and PC comparison at the top level.

## Interface
Parameters:
- `P_COLD_CYCLES`, 16'd2: number of disabled warm-up cycles after reset; must be ≥1.
- `P_MAX_PC`, 16'd32: largest PC value the core may execute at.
- `P_CYCLE_COUNT_WIDTH`, 32: width of the enabled-cycle counter.

Ports:
- `I_CLK`  in  1: single clock; all state changes on its rising edge.
- `I_NRESET`  in  1: reset, synchronous, active-low.
- `I_RUN`  in  1: level; 1 = free-run requested.
- `I_STEP`  in  1: single-step request; rising edge acts.
- `I_BREAK_EN`  in  1: breakpoint compare enable.
- `I_BREAK_PC`  in  16: breakpoint address.
- `I_PC`  in  16: current PC from the core.
- `O_CR16_ENABLE`  out  1: core enable; combinational.
- `O_STATE`  out  3: state code.
- `O_DONE`  out  1: 1 in DONE.
- `O_CYCLE_COUNT`  out  `P_CYCLE_COUNT_WIDTH`: number of cycles with `O_CR16_ENABLE`=1.

`I_RUN`, `I_STEP` and `I_BREAK_*` must be synchronous to `I_CLK`. Debounce and synchronisation happen upstream.

## Operation
States and codes: COLD=0, PAUSE=1, RUN=2, STEP=3, DONE=4.

Definitions:
- `over` = `I_PC > P_MAX_PC` (unsigned).
- `step_edge` = `I_STEP & ~step_q`, where `step_q` is `I_STEP` registered.
- `bp_hit` = `I_BREAK_EN & (I_PC == I_BREAK_PC) & ~skip`.
- `O_CR16_ENABLE` = `(state==RUN | state==STEP) & ~over & ~bp_hit`.

Transitions:
- **COLD:** `cold_cnt` increments each cycle. When `cold_cnt == P_COLD_CYCLES-1`, go to PAUSE.
- **PAUSE:**
  - `over` → DONE.
  - Else `I_RUN` → RUN.
  - Else `step_edge` → STEP.
  - `I_RUN` and `step_edge` together: RUN wins.
  - Leaving PAUSE for RUN or STEP sets `skip`=1, so the core can resume from the breakpoint PC.
- **RUN:**
  - `over` → DONE.
  - Else `bp_hit` → PAUSE.
  - Else `~I_RUN` → PAUSE.
- **STEP:**
  - `over` → DONE.
  - Else → PAUSE after exactly one cycle.
  - `skip` is always 1 in STEP, so a breakpoint never blocks a step.
- **DONE:** terminal until reset. `O_DONE`=1.
- `step_edge` outside PAUSE is discarded; it is not queued.

The `skip` flag:
- Cleared after the first cycle in which `O_CR16_ENABLE`=1.
- Cleared on entry to PAUSE.

Cycle counter:
- Increments when `O_CR16_ENABLE`=1.
- Saturates at all-ones with no wrap.

## Timing
Reset (`I_NRESET`=0 at a rising edge) sets:
- state COLD, `cold_cnt`=0, `step_q`=0, `skip`=0.
- `O_CR16_ENABLE`=0, `O_STATE`=0, `O_DONE`=0, `O_CYCLE_COUNT`=0.

Reset applies from any state, mid-run included, and always returns to COLD with the warm-up repeated.

Warm-up:
- PAUSE is first entered `P_COLD_CYCLES` edges after reset release.
- `O_CR16_ENABLE`=0 throughout warm-up.

Enable timing:
- `O_CR16_ENABLE` responds in the same cycle to `I_PC`. This prevents any overshoot past `P_MAX_PC` or past a breakpoint.

Latencies (state is registered, so all are 1 cycle):
- `I_RUN` sampled high in PAUSE at edge n: RUN from n, enable high in cycle n..n+1.
- `I_STEP` rises before edge n in PAUSE: STEP in cycle n..n+1, exactly one enabled cycle, PAUSE at edge n+1.
- `I_RUN` falling in RUN: PAUSE at the next edge. The enable stays high in the cycle where `I_RUN` is low.

## Configuration
Macro: `CR16_RUN_CTRL_BREAKPOINT_EN`.
- **Defined:** breakpoint logic as specified.
- **Undefined:**
  - `bp_hit` is tied to 0 and `skip` is removed.
  - `I_BREAK_EN` and `I_BREAK_PC` remain as ports but are ignored.
  - All other behaviour is unchanged.

## Test plan
- Reset released, `P_COLD_CYCLES`=2: `O_STATE` reads 0, 0, then 1; `O_CR16_ENABLE` stays 0; `O_CYCLE_COUNT`=0.
- Free-run: in PAUSE, `I_RUN`=1, bench PC increments per enabled cycle from 0. Enable drops in the cycle `I_PC`=33, `O_STATE`=4, `O_DONE`=1, `O_CYCLE_COUNT`=33.
- Step:
  - In PAUSE, three isolated `I_STEP` pulses give exactly 3 enabled cycles, and `O_CYCLE_COUNT`=3.
  - `I_STEP` held high for 10 cycles gives 1 enabled cycle.
- Breakpoint (macro defined), `I_BREAK_PC`=5, `I_BREAK_EN`=1, run from PC 0:
  - Pauses with `I_PC`=5 and `O_CYCLE_COUNT`=5.
  - `I_RUN` toggled 0→1 resumes, and PC passes 5.
- Breakpoint (macro undefined): same stimulus runs through to DONE with no pause at 5.
- Reset mid-run at PC 10: next state COLD, `O_CYCLE_COUNT`=0, enable 0, and warm-up repeats.
